// File: rtl/fp_sat_accum.sv
// fp_sat_accum
// ------------
// Saturating fixed-point accumulator for the output of the fixed-point
// multiplier. Samples flagged as overflow or underflow are replaced with
// the positive or negative full-scale value. N_ACC accepted samples are
// summed in a widened accumulator. One saturated W_len-bit result is then
// presented through a valid/ready handshake.
//
// Parameters:
//   W_len    word length of the input samples and of the result
//   W_fract  fractional bits; the format passes through and is not shifted
//   N_ACC    samples per result (>= 1)
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   in_valid    product/overflow/underflow hold a sample
//   in_ready    block accepts a sample this cycle
//   product     signed sample
//   overflow    sample overflowed positively (wins over underflow)
//   underflow   sample overflowed negatively
//   out_valid   sum holds a completed result
//   out_ready   downstream accepts the result
//   sum         signed, saturated result
//   sum_sat     sum was clamped
//
// Optional feature, macro FP_ACC_STICKY_EN:
//   clr_sticky  synchronous clear of sat_sticky (a set in the same cycle wins)
//   sat_sticky  set by any flagged accepted sample or any saturated result
module fp_sat_accum #(
    parameter int W_len   = 16,
    parameter int W_fract = 14,
    parameter int N_ACC   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [W_len-1:0] product,
    input  logic                    overflow,
    input  logic                    underflow,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [W_len-1:0] sum,
    output logic                    sum_sat
`ifdef FP_ACC_STICKY_EN
    ,
    input  logic                    clr_sticky,
    output logic                    sat_sticky
`endif
);

    // The extra guard bit above $clog2(N_ACC) holds a full-scale negative
    // run without wrapping.
    localparam int ACC_W = W_len + $clog2(N_ACC) + 1;
    localparam int CNT_W = (N_ACC > 1) ? $clog2(N_ACC) : 1;

    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(N_ACC - 1);
    localparam logic signed [W_len-1:0] MAX_VAL  = {1'b0, {(W_len-1){1'b1}}};
    localparam logic signed [W_len-1:0] MIN_VAL  = {1'b1, {(W_len-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] MAX_EXT  = {{(ACC_W-W_len){1'b0}}, MAX_VAL};
    localparam logic signed [ACC_W-1:0] MIN_EXT  = {{(ACC_W-W_len){1'b1}}, MIN_VAL};

    // Reject parameter sets that cannot describe a valid fixed-point format.
    if (N_ACC < 1 || W_fract < 0 || W_fract >= W_len) begin : g_bad_params
        $error("fp_sat_accum: need N_ACC >= 1 and 0 <= W_fract < W_len");
    end

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t                    state;
    state_t                    next_state;
    logic signed [ACC_W-1:0]   acc;
    logic        [CNT_W-1:0]   cnt;
    logic signed [W_len-1:0]   sample;
    logic signed [ACC_W-1:0]   sample_ext;
    logic signed [ACC_W-1:0]   total;
    logic                      accept;
    logic                      last;
    logic                      sat_hi;
    logic                      sat_lo;

    // The handshake outputs decode only from the registered state. This
    // keeps every combinational path away from in_valid and out_ready.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == LAST_CNT);

    // Replace flagged samples with full scale. Overflow wins when both
    // flags are set. The sample is then sign-extended and added to the
    // running total.
    always_comb begin
        sample = product;
        if (overflow) begin
            sample = MAX_VAL;
        end else if (underflow) begin
            sample = MIN_VAL;
        end
        sample_ext = {{(ACC_W-W_len){sample[W_len-1]}}, sample};
        total      = acc + sample_ext;
        sat_hi     = (total > MAX_EXT);
        sat_lo     = (total < MIN_EXT);
    end

    // Register the handshake state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    // Move to DONE on the N_ACC-th accept. Return to ACCUM only after
    // downstream takes the result.
    always_comb begin
        next_state = state;
        case (state)
            ACCUM:   if (accept && last) next_state = DONE;
            DONE:    if (out_ready)      next_state = ACCUM;
            default: next_state = ACCUM;
        endcase
    end

    // Accumulate accepted samples. On the final sample, clamp the total into
    // sum and restart the accumulator. The sum register is written only on an
    // accept, so it stays stable throughout DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            cnt     <= '0;
            sum     <= '0;
            sum_sat <= 1'b0;
        end else if (accept) begin
            if (last) begin
                acc     <= '0;
                cnt     <= '0;
                sum_sat <= sat_hi || sat_lo;
                if (sat_hi) begin
                    sum <= MAX_VAL;
                end else if (sat_lo) begin
                    sum <= MIN_VAL;
                end else begin
                    sum <= total[W_len-1:0];
                end
            end else begin
                acc <= total;
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef FP_ACC_STICKY_EN
    logic sticky_set;

    assign sticky_set = accept && (overflow || underflow || (last && (sat_hi || sat_lo)));

    // Record any saturation event until software clears it. A set in the
    // same cycle as a clear takes priority, so no event is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_sticky <= 1'b0;
        end else if (sticky_set) begin
            sat_sticky <= 1'b1;
        end else if (clr_sticky) begin
            sat_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fp_sat_accum.sv
// tb_fp_sat_accum
// ---------------
// Directed testbench for fp_sat_accum with N_ACC = 4. A table of
// four-sample blocks is applied, each with a hand-computed result. Short
// hand-written sequences then cover a stalled DONE, reset during
// accumulation, reset during DONE and, when FP_ACC_STICKY_EN is defined,
// the sticky flag.
module tb_fp_sat_accum;

    localparam int W_LEN = 16;
    localparam int N_ACC = 4;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [W_LEN-1:0]  product;
    logic              overflow;
    logic              underflow;
    logic              out_valid;
    logic              out_ready;
    logic [W_LEN-1:0]  sum;
    logic              sum_sat;
`ifdef FP_ACC_STICKY_EN
    logic              clr_sticky;
    logic              sat_sticky;
`endif

    int compared;
    int mismatched;

    typedef struct {
        string                  name;
        logic [3:0][W_LEN-1:0]  prod;
        logic [3:0]             ovf;
        logic [3:0]             udf;
        logic [W_LEN-1:0]       exp_sum;
        logic                   exp_sat;
    } vec_t;

    vec_t vecs[9];

    fp_sat_accum #(
        .W_len  (W_LEN),
        .W_fract(14),
        .N_ACC  (N_ACC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .overflow  (overflow),
        .underflow (underflow),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .sum_sat   (sum_sat)
`ifdef FP_ACC_STICKY_EN
        ,
        .clr_sticky(clr_sticky),
        .sat_sticky(sat_sticky)
`endif
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build one table record. Sample 0 is presented first.
    function automatic vec_t mkVec(input string name,
                                   input logic [W_LEN-1:0] p0, input logic [W_LEN-1:0] p1,
                                   input logic [W_LEN-1:0] p2, input logic [W_LEN-1:0] p3,
                                   input logic [3:0] ovf, input logic [3:0] udf,
                                   input logic [W_LEN-1:0] exp_sum, input logic exp_sat);
        vec_t v;
        v.name    = name;
        v.prod[0] = p0;
        v.prod[1] = p1;
        v.prod[2] = p2;
        v.prod[3] = p3;
        v.ovf     = ovf;
        v.udf     = udf;
        v.exp_sum = exp_sum;
        v.exp_sat = exp_sat;
        return v;
    endfunction

    // Drive one cycle of input on the falling edge. Any checks that follow
    // observe the state between two rising edges.
    task automatic applyStimulus(input logic v, input logic [W_LEN-1:0] p,
                                 input logic o, input logic u);
        @(negedge clk);
        in_valid  = v;
        product   = p;
        overflow  = o;
        underflow = u;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Feed four samples with out_ready held high. Check that the result
    // appears for exactly one cycle, then that input is accepted again.
    task automatic runVector(input vec_t v);
        for (int i = 0; i < N_ACC; i++) begin
            applyStimulus(1'b1, v.prod[i], v.ovf[i], v.udf[i]);
            checkOutput($sformatf("%s.in_ready[%0d]", v.name, i), 32'(in_ready), 32'd1);
            checkOutput($sformatf("%s.out_valid[%0d]", v.name, i), 32'(out_valid), 32'd0);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput({v.name, ".done_valid"}, 32'(out_valid), 32'd1);
        checkOutput({v.name, ".done_in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({v.name, ".sum"}, 32'(sum), 32'(v.exp_sum));
        checkOutput({v.name, ".sum_sat"}, 32'(sum_sat), 32'(v.exp_sat));
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput({v.name, ".after_valid"}, 32'(out_valid), 32'd0);
        checkOutput({v.name, ".after_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        in_valid   = 1'b0;
        product    = '0;
        overflow   = 1'b0;
        underflow  = 1'b0;
        out_ready  = 1'b1;
`ifdef FP_ACC_STICKY_EN
        clr_sticky = 1'b0;
`endif

        vecs[0] = mkVec("quarter_x4", 16'h1000, 16'h1000, 16'h1000, 16'h1000, 4'b0000, 4'b0000, 16'h4000, 1'b0);
        vecs[1] = mkVec("half_x4_sat", 16'h2000, 16'h2000, 16'h2000, 16'h2000, 4'b0000, 4'b0000, 16'h7FFF, 1'b1);
        vecs[2] = mkVec("ovf_subst", 16'h1234, 16'hC000, 16'hC000, 16'hC000, 4'b0001, 4'b0000, 16'hBFFF, 1'b0);
        vecs[3] = mkVec("udf_x4_sat", 16'h0000, 16'h1111, 16'h2222, 16'h3333, 4'b0000, 4'b1111, 16'h8000, 1'b1);
        vecs[4] = mkVec("cancel_zero", 16'h1000, 16'hF000, 16'h0100, 16'hFF00, 4'b0000, 4'b0000, 16'h0000, 1'b0);
        vecs[5] = mkVec("max_exact", 16'h2000, 16'h2000, 16'h2000, 16'h1FFF, 4'b0000, 4'b0000, 16'h7FFF, 1'b0);
        vecs[6] = mkVec("min_exact", 16'hE000, 16'hE000, 16'hE000, 16'hE000, 4'b0000, 4'b0000, 16'h8000, 1'b0);
        vecs[7] = mkVec("neg_sat", 16'hA000, 16'hA000, 16'hA000, 16'hA000, 4'b0000, 4'b0000, 16'h8000, 1'b1);
        vecs[8] = mkVec("both_flags", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b1111, 4'b1111, 16'h7FFF, 1'b1);

        // Reset values.
        #2;
        checkOutput("rst.in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst.sum", 32'(sum), 32'd0);
        checkOutput("rst.sum_sat", 32'(sum_sat), 32'd0);
`ifdef FP_ACC_STICKY_EN
        checkOutput("rst.sat_sticky", 32'(sat_sticky), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < 9; k++) begin
            runVector(vecs[k]);
        end

        // Stall DONE for five cycles while a full-scale sample is offered.
        // That sample must be dropped.
        out_ready = 1'b0;
        for (int i = 0; i < N_ACC; i++) begin
            applyStimulus(1'b1, 16'h1000, 1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'h7FFF, 1'b0, 1'b0);
            checkOutput($sformatf("stall.out_valid[%0d]", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("stall.in_ready[%0d]", i), 32'(in_ready), 32'd0);
            checkOutput($sformatf("stall.sum[%0d]", i), 32'(sum), 32'h4000);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        out_ready = 1'b1;
        checkOutput("stall.release_valid", 32'(out_valid), 32'd1);
        runVector(vecs[0]);

        // Reset after two accepts. The partial sum and the old result must be
        // discarded immediately.
        applyStimulus(1'b1, 16'h1000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h1000, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("rst_mid.in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_mid.out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_mid.sum", 32'(sum), 32'd0);
        checkOutput("rst_mid.sum_sat", 32'(sum_sat), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        runVector(vecs[0]);

        // Reset during a stalled DONE. The pending result must vanish at once.
        out_ready = 1'b0;
        for (int i = 0; i < N_ACC; i++) begin
            applyStimulus(1'b1, 16'h2000, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("rst_done.pre_valid", 32'(out_valid), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("rst_done.out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_done.in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_done.sum", 32'(sum), 32'd0);
        checkOutput("rst_done.sum_sat", 32'(sum_sat), 32'd0);
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        runVector(vecs[0]);

`ifdef FP_ACC_STICKY_EN
        // A clean block leaves the flag clear. Underflow samples set it, and
        // it holds until clr_sticky is pulsed.
        checkOutput("sticky.clean", 32'(sat_sticky), 32'd0);
        runVector(vecs[3]);
        checkOutput("sticky.set", 32'(sat_sticky), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("sticky.hold", 32'(sat_sticky), 32'd1);
        clr_sticky = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        clr_sticky = 1'b0;
        checkOutput("sticky.cleared", 32'(sat_sticky), 32'd0);
        // A flagged accept in the same cycle as a clear leaves the flag set.
        applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0);
        clr_sticky = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        clr_sticky = 1'b0;
        checkOutput("sticky.set_wins", 32'(sat_sticky), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fp_sat_accum.md
# fp_sat_accum

Saturating fixed-point accumulator that sits directly downstream of the fixed-point multiplier. It consumes the registered product and its overflow/underflow flags, substitutes full-scale values for flagged samples, and sums `N_ACC` accepted samples in a widened accumulator. It then presents one saturated `W_len`-bit result through a valid/ready handshake. Typical use is dot-product and FIR-tap reduction.

## Interface
- `W_len`, 16: word length of input samples and of the result.
- `W_fract`, 14: fractional bits, the same for input and result. The format passes through unchanged and no shifting is applied.
- `N_ACC`, 8: number of samples per result, ≥1.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low. Asserting it (0) immediately clears all state.
- `in_valid` input 1: `product`/`overflow`/`underflow` hold a sample. The integrator must align this with the multiplier's registered output (one cycle after the operands).
- `in_ready` output 1: block accepts a sample this cycle.
- `product` input `W_len`: signed sample.
- `overflow` input 1: sample overflowed positively.
- `underflow` input 1: sample overflowed negatively.
- `out_valid` output 1: `sum` holds a completed result.
- `out_ready` input 1: downstream accepts the result.
- `sum` output `W_len`: signed, saturated result.
- `sum_sat` output 1: `sum` was clamped.

## Operation
- Accept occurs when `in_valid && in_ready` at a rising edge.
- Sample substitution:
  - `overflow`=1 → `2^(W_len-1)-1`. If both flags are set, `overflow` wins.
  - `underflow`=1 only → `-2^(W_len-1)`.
  - No flag set → `product`.
- The accumulator is signed, `W_len+$clog2(N_ACC)+1` bits wide, and cannot wrap internally.
- Sample counter `cnt`: 0..`N_ACC-1`.
- FSM states:
  - ACCUM: `in_ready`=1, `out_valid`=0.
    - Accept with `cnt`<`N_ACC-1`: `acc += sample`, `cnt++`.
    - Accept with `cnt`=`N_ACC-1`: compute `t = acc + sample`, register saturated `t` into `sum`, set `sum_sat`, clear `acc`/`cnt`, go to DONE.
  - DONE: `in_ready`=0, `out_valid`=1, and `sum`/`sum_sat` are held stable.
    - `out_ready`=1: go to ACCUM.
    - `in_valid` is ignored; samples presented here are dropped and not counted.
- Saturation rules:
  - `t > 2^(W_len-1)-1` → `sum` = max, `sum_sat`=1.
  - `t < -2^(W_len-1)` → `sum` = min, `sum_sat`=1.
  - Otherwise `sum = t[W_len-1:0]`, `sum_sat`=0.
- `N_ACC`=1: every accepted sample goes directly to DONE.
- `out_valid` must not drop, and `sum` must not change, until the handshake completes.

## Timing
- Reset values: state ACCUM, `acc`=0, `cnt`=0, `sum`=0, `sum_sat`=0, `out_valid`=0, `in_ready`=1.
- `in_ready` and `out_valid` are decoded from registered state, with no combinational path from `out_ready` or `in_valid`.
- Latency: `out_valid` rises the cycle after the `N_ACC`-th accept.
- Throughput: at most one result per `N_ACC+1` cycles (the DONE cycle blocks input).
- `out_ready` held high: DONE lasts exactly one cycle, and ACCUM accepts again on the next cycle.
- Reset mid-accumulation or mid-DONE: partial sum and any pending result are discarded, and outputs take reset values asynchronously.

## Configuration
- `FP_ACC_STICKY_EN` defined:
  - Adds input `clr_sticky` (1 bit) and output `sat_sticky` (1 bit, reset 0).
  - `sat_sticky` is set on any accepted sample with `overflow` or `underflow`, and on any result with `sum_sat`=1.
  - It is cleared synchronously by `clr_sticky`=1. If set and clear occur in the same cycle, set wins.
- `FP_ACC_STICKY_EN` undefined: both ports and the sticky logic are absent, and all other behaviour is identical.

## Test plan
All scenarios use defaults except `N_ACC`=4.
1. Four accepts of `0x1000` (0.25), `out_ready`=1 → `out_valid` for one cycle after the 4th accept, `sum`=`0x4000`, `sum_sat`=0.
2. Four accepts of `0x2000` (0.5) → `sum`=`0x7FFF`, `sum_sat`=1.
3. First sample `0x1234` with `overflow`=1, then three samples of `0xC000` → `sum`=`0xBFFF`, `sum_sat`=0 (`0x7FFF` substituted for the first sample).
4. Four samples with `underflow`=1 → `sum`=`0x8000`, `sum_sat`=1. With the macro defined, `sat_sticky`=1 until `clr_sticky` is pulsed.
5. `out_ready`=0 for 5 cycles after DONE, with `in_valid`=1 and `0x7FFF` presented → `out_valid`/`sum` held and `in_ready`=0. After release, the next four `0x1000` samples give `sum`=`0x4000`.
6. Assert `reset` after 2 accepts → outputs reset immediately. Four fresh `0x1000` samples after release give `sum`=`0x4000`.
